fx_bus_arb: RTL and testbench

Arbitrates the shared fx register bus between NREQ requesters, e.g. the host bridge and an on-chip configuration sequencer writing cfg_ave and debug registers. Each access is one fx_wr or fx_rd strobe. Read data is returned from the OR-combined slave fx_q after a fixed slave read latency. The block sits between the requesters and all fx slave register banks, including the AD register bank.

---
 rtl/fx_bus_arb_pkg.sv | 37 +++
 rtl/fx_bus_arb_if.sv | 31 +++
 rtl/fx_bus_arb_rr_pick.sv | 33 +++
 rtl/fx_bus_arb.sv | 143 ++++++++++++++
 tb/tb_fx_bus_arb.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fx_bus_arb_pkg.sv
// fx_bus_pkg: shared widths, FSM state type and the per-requester field
// extractor for the fx bus arbiter.
//   FX_AW/FX_DW    : fx bus address / data widths
//   FX_DEVW        : dev_id field width at the top of the address
//   FX_MAXREQ      : largest legal requester count (sizes the extractor)
package fx_bus_pkg;

   localparam int FX_AW     = 22;
   localparam int FX_DW     = 8;
   localparam int FX_DEVW   = 6;
   localparam int FX_MAXREQ = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} fx_state_e;

   typedef struct packed {
      logic                     wr;
      logic [FX_DEVW-1:0]       dev;
      logic [FX_AW-FX_DEVW-1:0] regn;
      logic [FX_DW-1:0]         wdata;
   } fx_req_t;

   // Pull requester i's access out of the flattened request vectors. Callers
   // zero-extend their vectors to FX_MAXREQ entries.
   function automatic fx_req_t fx_req_sel(
      input logic [FX_MAXREQ-1:0]       wr,
      input logic [FX_MAXREQ*FX_AW-1:0] addr,
      input logic [FX_MAXREQ*FX_DW-1:0] wdata,
      input logic [1:0]                 i
   );
      fx_req_t r;
      r.wr                 = wr[i];
      {r.dev, r.regn}      = addr[i*FX_AW +: FX_AW];
      r.wdata              = wdata[i*FX_DW +: FX_DW];
      return r;
   endfunction

endpackage

// File: rtl/fx_bus_arb_if.sv
// fx_bus_arb_if: requester handshake plus fx register bus, bundled.
//   master : requester / slave-bank side (drives req_*, fx_q)
//   slave  : arbiter side (drives req_rdy, rsp_*, fx_wr/fx_rd strobes)
interface fx_bus_arb_if #(parameter int NREQ = 2);
   import fx_bus_pkg::*;

   logic [NREQ-1:0]       req_vld;
   logic [NREQ-1:0]       req_wr;
   logic [NREQ*FX_AW-1:0] req_addr;
   logic [NREQ*FX_DW-1:0] req_wdata;
   logic [NREQ-1:0]       req_rdy;
   logic [NREQ-1:0]       rsp_vld;
   logic [FX_DW-1:0]      rsp_data;
   logic                  fx_wr;
   logic [FX_AW-1:0]      fx_waddr;
   logic [FX_DW-1:0]      fx_data;
   logic                  fx_rd;
   logic [FX_AW-1:0]      fx_raddr;
   logic [FX_DW-1:0]      fx_q;

   modport master (
      output req_vld, req_wr, req_addr, req_wdata, fx_q,
      input  req_rdy, rsp_vld, rsp_data, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr
   );

   modport slave (
      input  req_vld, req_wr, req_addr, req_wdata, fx_q,
      output req_rdy, rsp_vld, rsp_data, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr
   );

endinterface

// File: rtl/fx_bus_arb_rr_pick.sv
// fx_rr_pick: combinational round-robin picker.
//   req : request vector
//   ptr : last winner; the search starts at ptr+1 mod NREQ
//   gnt : one-hot grant (all zero when req is zero)
//   idx : index of the granted requester
module fx_rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);

   // Both loops unroll, so every req bit is selected by a constant index.
   always_comb begin
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               idx    = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/fx_bus_arb.sv
// fx_bus_arb: arbitrates NREQ requesters onto the shared fx register bus,
// one access at a time, and returns read data RD_LAT cycles after fx_rd.
//   clk_sys, rst : clock, asynchronous active-high reset
//   bus (slave)  : req_vld/req_wr/req_addr/req_wdata in, req_rdy/rsp_vld/
//                  rsp_data out, fx_wr/fx_waddr/fx_data/fx_rd/fx_raddr out,
//                  fx_q in (OR of all slave read data)
// Build option FX_ARB_PRIO_EN: fixed priority (requester 0 highest) instead
// of round-robin; the pointer register disappears.
module fx_bus_arb
   import fx_bus_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int RD_LAT = 1
) (
   input logic         clk_sys,
   input logic         rst,
   fx_bus_arb_if.slave bus
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = 2;

   fx_state_e        state_q;
   logic [IW-1:0]    win_q;
   logic [CW-1:0]    cnt_q;
   logic [NREQ-1:0]  req_rdy_q, rsp_vld_q;
   logic [FX_DW-1:0] rsp_data_q, fx_data_q;
   logic [FX_AW-1:0] fx_waddr_q, fx_raddr_q;
   logic             fx_wr_q, fx_rd_q;

   logic [NREQ-1:0]  gnt;
   logic [IW-1:0]    gnt_idx;
   fx_req_t          win_req;

`ifdef FX_ARB_PRIO_EN
   // Descending scan so the lowest requesting index wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_vld[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            gnt_idx = IW'(i);
         end
      end
   end
`else
   logic [IW-1:0] ptr_q;

   fx_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req (bus.req_vld),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gnt_idx)
   );
`endif

   assign win_req = fx_req_sel(FX_MAXREQ'(bus.req_wr),
                               (FX_MAXREQ*FX_AW)'(bus.req_addr),
                               (FX_MAXREQ*FX_DW)'(bus.req_wdata),
                               2'(gnt_idx));

   // Strobes and req_rdy are loaded on the IDLE->ISSUE edge so they are
   // visible exactly during the ISSUE cycle; every other cycle they return
   // to zero, which keeps the bus at its idle values.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         win_q      <= '0;
`ifndef FX_ARB_PRIO_EN
         ptr_q      <= '0;
`endif
         cnt_q      <= '0;
         req_rdy_q  <= '0;
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
         fx_wr_q    <= 1'b0;
         fx_rd_q    <= 1'b0;
         fx_waddr_q <= '0;
         fx_raddr_q <= '0;
         fx_data_q  <= '0;
      end else begin
         req_rdy_q  <= '0;
         rsp_vld_q  <= '0;
         fx_wr_q    <= 1'b0;
         fx_rd_q    <= 1'b0;
         fx_waddr_q <= '0;
         fx_raddr_q <= '0;
         fx_data_q  <= '0;
         case (state_q)
            IDLE: begin
               if (|bus.req_vld) begin
                  win_q     <= gnt_idx;
`ifndef FX_ARB_PRIO_EN
                  ptr_q     <= gnt_idx;
`endif
                  req_rdy_q <= gnt;
                  if (win_req.wr) begin
                     fx_wr_q    <= 1'b1;
                     fx_waddr_q <= {win_req.dev, win_req.regn};
                     fx_data_q  <= win_req.wdata;
                  end else begin
                     fx_rd_q    <= 1'b1;
                     fx_raddr_q <= {win_req.dev, win_req.regn};
                  end
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (fx_rd_q) begin
                  cnt_q   <= CW'(RD_LAT);
                  state_q <= WAIT;
               end else begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               // cnt_q==1 marks the cycle RD_LAT after the strobe, when fx_q
               // is valid; rsp_vld then lands in the following IDLE cycle.
               if (cnt_q == CW'(1)) begin
                  rsp_data_q       <= bus.fx_q;
                  rsp_vld_q[win_q] <= 1'b1;
                  state_q          <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_rdy  = req_rdy_q;
   assign bus.rsp_vld  = rsp_vld_q;
   assign bus.rsp_data = rsp_data_q;
   assign bus.fx_wr    = fx_wr_q;
   assign bus.fx_waddr = fx_waddr_q;
   assign bus.fx_data  = fx_data_q;
   assign bus.fx_rd    = fx_rd_q;
   assign bus.fx_raddr = fx_raddr_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// tb_fx_bus_arb: scoreboard bench for fx_bus_arb. Two instances: dut_a
// (RD_LAT=1) carries most traffic, dut_b (RD_LAT=3) the long-latency case.
// Expected bus events (write strobe, read strobe, read response) are queued
// with the cycle distance from the previous event; monitors pop and compare.
module tb_fx_bus_arb;

   localparam int K_W = 0;
   localparam int K_R = 1;
   localparam int K_P = 2;

   typedef struct packed {
      logic        wr;
      logic [21:0] addr;
      logic [7:0]  wdata;
   } acc_t;

   typedef struct {
      int         kind;
      logic [1:0] vec;
      logic [21:0] addr;
      logic [7:0] data;
      int         dt;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fx_bus_arb_if #(.NREQ(2)) bus_a ();
   fx_bus_arb_if #(.NREQ(2)) bus_b ();

   fx_bus_arb #(.NREQ(2), .RD_LAT(1)) dut_a (.clk_sys(clk), .rst(rst), .bus(bus_a));
   fx_bus_arb #(.NREQ(2), .RD_LAT(3)) dut_b (.clk_sys(clk), .rst(rst), .bus(bus_b));

   acc_t ra0[$], ra1[$], rb0[$];
   ev_t  qa[$], qb[$];
   int   cmp_n = 0;
   int   bad_n = 0;
   int   cyc = 0;
   int   last_a = 0, last_b = 0;

   always @(posedge clk) cyc++;

   // ---------------- slave bank model ----------------
   // dev 1: reg 0x81 is a read-only ID returning 0x81, reg 0x50 is unmapped
   // (0x55), other regs 0x00xx are storage. Any other dev_id: no slave.
   logic [7:0] mem [256];
   logic [7:0] pb1, pb2;

   function automatic logic [7:0] rd_model(input logic [21:0] a);
      if (a[21:16] == 6'd1 && a[15:0] == 16'h0081) return 8'h81;
      if (a[21:16] == 6'd1 && a[15:8] == 8'h00 && a[7:0] != 8'h50) return mem[a[7:0]];
      if (a[21:16] == 6'd1) return 8'h55;
      return 8'h00;
   endfunction

   always @(posedge clk) begin
      if (bus_a.fx_wr && bus_a.fx_waddr[21:8] == 14'h0100) mem[bus_a.fx_waddr[7:0]] <= bus_a.fx_data;
      if (bus_b.fx_wr && bus_b.fx_waddr[21:8] == 14'h0100) mem[bus_b.fx_waddr[7:0]] <= bus_b.fx_data;
      bus_a.fx_q <= bus_a.fx_rd ? rd_model(bus_a.fx_raddr) : 8'h00;
      pb1        <= bus_b.fx_rd ? rd_model(bus_b.fx_raddr) : 8'h00;
      pb2        <= pb1;
      bus_b.fx_q <= pb2;
   end

   // ---------------- requester drivers ----------------
   // Each requester presents the head of its queue and pops it on req_rdy.
   always @(posedge clk) begin
      acc_t f0, f1, g0;
      #1;
      if (bus_a.req_rdy[0] && ra0.size() != 0) void'(ra0.pop_front());
      if (bus_a.req_rdy[1] && ra1.size() != 0) void'(ra1.pop_front());
      if (bus_b.req_rdy[0] && rb0.size() != 0) void'(rb0.pop_front());
      f0 = '0; f1 = '0; g0 = '0;
      if (ra0.size() != 0) f0 = ra0[0];
      if (ra1.size() != 0) f1 = ra1[0];
      if (rb0.size() != 0) g0 = rb0[0];
      bus_a.req_vld   = {ra1.size() != 0, ra0.size() != 0};
      bus_a.req_wr    = {f1.wr, f0.wr};
      bus_a.req_addr  = {f1.addr, f0.addr};
      bus_a.req_wdata = {f1.wdata, f0.wdata};
      bus_b.req_vld   = {1'b0, rb0.size() != 0};
      bus_b.req_wr    = {1'b0, g0.wr};
      bus_b.req_addr  = {22'h0, g0.addr};
      bus_b.req_wdata = {8'h0, g0.wdata};
   end

   task automatic post(input int inst, input int idx, input logic wr,
                       input logic [21:0] addr, input logic [7:0] wdata);
      acc_t a;
      a.wr = wr; a.addr = addr; a.wdata = wdata;
      if (inst == 1) rb0.push_back(a);
      else if (idx == 0) ra0.push_back(a);
      else ra1.push_back(a);
   endtask

   task automatic ex(input int inst, input int kind, input logic [1:0] vec,
                     input logic [21:0] addr, input logic [7:0] data, input int dt);
      ev_t e;
      e.kind = kind; e.vec = vec; e.addr = addr; e.data = data; e.dt = dt;
      if (inst == 0) qa.push_back(e); else qb.push_back(e);
   endtask

   // ---------------- monitors / scoreboard ----------------
   task automatic score(input int inst, input ev_t o);
      ev_t e;
      int  last;
      cmp_n++;
      if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
         bad_n++;
         $display("FAIL unexpected_ev inst%0d got kind=%0d vec=%b addr=%h data=%h, want none",
                  inst, o.kind, o.vec, o.addr, o.data);
      end else begin
         if (inst == 0) begin e = qa.pop_front(); last = last_a; end
         else begin e = qb.pop_front(); last = last_b; end
         if (o.kind != e.kind || o.vec != e.vec || o.addr != e.addr || o.data != e.data ||
             (e.dt >= 0 && cyc - last != e.dt)) begin
            bad_n++;
            $display("FAIL ev_inst%0d got kind=%0d vec=%b addr=%h data=%h dt=%0d, want kind=%0d vec=%b addr=%h data=%h dt=%0d",
                     inst, o.kind, o.vec, o.addr, o.data, cyc - last,
                     e.kind, e.vec, e.addr, e.data, e.dt);
         end
      end
      if (inst == 0) last_a = cyc; else last_b = cyc;
   endtask

   function automatic ev_t mk(input logic [1:0] rdy, input logic [1:0] rv,
                              input logic wr, input logic rd,
                              input logic [21:0] wa, input logic [21:0] ra,
                              input logic [7:0] wd, input logic [7:0] rdat);
      ev_t o;
      o.dt = 0;
      if (rv != 2'b00)  begin o.kind = K_P; o.vec = rv;  o.addr = 22'h0; o.data = rdat;  end
      else if (wr)      begin o.kind = K_W; o.vec = rdy; o.addr = wa;    o.data = wd;    end
      else if (rd)      begin o.kind = K_R; o.vec = rdy; o.addr = ra;    o.data = 8'h00; end
      else              begin o.kind = 3;   o.vec = rdy; o.addr = 22'h0; o.data = 8'h00; end
      return o;
   endfunction

   // Idle bus check: address/data lines must be zero whenever not strobing.
   task automatic idle_chk(input int inst, input logic wr, input logic rd,
                           input logic [21:0] wa, input logic [21:0] ra, input logic [7:0] wd);
      cmp_n++;
      if ((!wr && (wa != 22'h0 || wd != 8'h00)) || (!rd && ra != 22'h0)) begin
         bad_n++;
         $display("FAIL idle_bus inst%0d got waddr=%h wdata=%h raddr=%h, want 0 when idle",
                  inst, wa, wd, ra);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus_a.req_rdy != 0 || bus_a.rsp_vld != 0 || bus_a.fx_wr || bus_a.fx_rd)
            score(0, mk(bus_a.req_rdy, bus_a.rsp_vld, bus_a.fx_wr, bus_a.fx_rd,
                        bus_a.fx_waddr, bus_a.fx_raddr, bus_a.fx_data, bus_a.rsp_data));
         if (bus_b.req_rdy != 0 || bus_b.rsp_vld != 0 || bus_b.fx_wr || bus_b.fx_rd)
            score(1, mk(bus_b.req_rdy, bus_b.rsp_vld, bus_b.fx_wr, bus_b.fx_rd,
                        bus_b.fx_waddr, bus_b.fx_raddr, bus_b.fx_data, bus_b.rsp_data));
         idle_chk(0, bus_a.fx_wr, bus_a.fx_rd, bus_a.fx_waddr, bus_a.fx_raddr, bus_a.fx_data);
         idle_chk(1, bus_b.fx_wr, bus_b.fx_rd, bus_b.fx_waddr, bus_b.fx_raddr, bus_b.fx_data);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] outs(input int inst);
      if (inst == 0)
         return {bus_a.req_rdy, bus_a.rsp_vld, bus_a.rsp_data, bus_a.fx_wr,
                 bus_a.fx_rd, bus_a.fx_data, bus_a.fx_waddr | bus_a.fx_raddr};
      return {bus_b.req_rdy, bus_b.rsp_vld, bus_b.rsp_data, bus_b.fx_wr,
              bus_b.fx_rd, bus_b.fx_data, bus_b.fx_waddr | bus_b.fx_raddr};
   endfunction

   // Wait (bounded) for every expected event, then idle a few cycles so a
   // stray event shows up as unexpected.
   task automatic drain(input int inst);
      int n;
      n = 0;
      while (((inst == 0) ? qa.size() : qb.size()) != 0 && n < 300) begin
         @(negedge clk); #1; n++;
      end
      chk($sformatf("pending_inst%0d", inst), 64'((inst == 0) ? qa.size() : qb.size()), 64'd0);
      if (inst == 0) qa.delete(); else qb.delete();
      repeat (6) @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outs_a", outs(0), 64'd0);
      chk("reset_outs_b", outs(1), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Both requesters loaded with 3 writes each, pointer at reset value.
`ifdef FX_ARB_PRIO_EN
      for (int k = 0; k < 3; k++)
         ex(0, K_W, 2'b01, 22'h010000 + 22'(k), 8'hA0 + 8'(k), (k == 0) ? -1 : 2);
      for (int k = 0; k < 3; k++)
         ex(0, K_W, 2'b10, 22'h010010 + 22'(k), 8'hB0 + 8'(k), 2);
`else
      for (int k = 0; k < 3; k++) begin
         ex(0, K_W, 2'b10, 22'h010010 + 22'(k), 8'hB0 + 8'(k), (k == 0) ? -1 : 2);
         ex(0, K_W, 2'b01, 22'h010000 + 22'(k), 8'hA0 + 8'(k), 2);
      end
`endif
      for (int k = 0; k < 3; k++) begin
         post(0, 0, 1'b1, 22'h010000 + 22'(k), 8'hA0 + 8'(k));
         post(0, 1, 1'b1, 22'h010010 + 22'(k), 8'hB0 + 8'(k));
      end
      drain(0);

      // cfg_ave write then readback from requester 0.
      ex(0, K_W, 2'b01, 22'h010020, 8'h05, -1);
      ex(0, K_R, 2'b01, 22'h010020, 8'h00, 2);
      ex(0, K_P, 2'b01, 22'h000000, 8'h05, 2);
      post(0, 0, 1'b1, 22'h010020, 8'h05);
      post(0, 0, 1'b0, 22'h010020, 8'h00);
      drain(0);

      // Requester 1 read; response only on rsp_vld[1], T+2.
      ex(0, K_R, 2'b10, 22'h010081, 8'h00, -1);
      ex(0, K_P, 2'b10, 22'h000000, 8'h81, 2);
      post(0, 1, 1'b0, 22'h010081, 8'h00);
      drain(0);

      // No slave (dev 0x3F) then unmapped register; next read issues in the
      // rsp_vld cycle's IDLE + 1.
      ex(0, K_R, 2'b01, 22'h3F0000, 8'h00, -1);
      ex(0, K_P, 2'b01, 22'h000000, 8'h00, 2);
      ex(0, K_R, 2'b01, 22'h010050, 8'h00, 1);
      ex(0, K_P, 2'b01, 22'h000000, 8'h55, 2);
      post(0, 0, 1'b0, 22'h3F0000, 8'h00);
      post(0, 0, 1'b0, 22'h010050, 8'h00);
      drain(0);

      // Reset during the WAIT cycle of a read: response must be dropped.
      ex(0, K_R, 2'b01, 22'h010081, 8'h00, -1);
      post(0, 0, 1'b0, 22'h010081, 8'h00);
      n = 0;
      while (qa.size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
      chk("rst_read_strobe_seen", 64'(qa.size()), 64'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_async_outs_a", outs(0), 64'd0);
      chk("rst_async_outs_b", outs(1), 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // Served normally after reset.
      ex(0, K_R, 2'b10, 22'h010020, 8'h00, -1);
      ex(0, K_P, 2'b10, 22'h000000, 8'h05, 2);
      post(0, 1, 1'b0, 22'h010020, 8'h00);
      drain(0);

      // RD_LAT=3: read then write from req0; write strobe at T+5.
      ex(1, K_R, 2'b01, 22'h010081, 8'h00, -1);
      ex(1, K_P, 2'b01, 22'h000000, 8'h81, 4);
      ex(1, K_W, 2'b01, 22'h010030, 8'hA7, 1);
      ex(1, K_R, 2'b01, 22'h010030, 8'h00, 2);
      ex(1, K_P, 2'b01, 22'h000000, 8'hA7, 4);
      post(1, 0, 1'b0, 22'h010081, 8'h00);
      post(1, 0, 1'b1, 22'h010030, 8'hA7);
      post(1, 0, 1'b0, 22'h010030, 8'h00);
      drain(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
      $finish;
   end

endmodule
